// File: rtl/mpadd_sequencer.sv
// mpadd_sequencer: multi-word ADD/ADC/SUB/SBC sequencer driving regfile addresses and adder opecode/carry.
// Define MPADD_ZERO_FLAG_EN to build the all-words-zero result flag (flag_z); otherwise flag_z is tied 0.
module mpadd_sequencer #(
  parameter int LEN_REG = 16,
  parameter int LEN_OPECODE = 6,
  parameter int LEN_ADDR = 4,
  parameter int LEN_CNT = 3,
  parameter logic [LEN_OPECODE-1:0] OPECODE_ADD = LEN_OPECODE'(8),
  parameter logic [LEN_OPECODE-1:0] OPECODE_ADC = LEN_OPECODE'(9),
  parameter logic [LEN_OPECODE-1:0] OPECODE_SUB = LEN_OPECODE'(10),
  parameter logic [LEN_OPECODE-1:0] OPECODE_SBC = LEN_OPECODE'(11)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_sub,
  input  logic [LEN_CNT-1:0]     req_len,
  input  logic [LEN_ADDR-1:0]    req_base_rd,
  input  logic [LEN_ADDR-1:0]    req_base_rs,
  input  logic                   abort,
  output logic [LEN_ADDR-1:0]    rf_raddr_rd,
  output logic [LEN_ADDR-1:0]    rf_raddr_rs,
  output logic                   rf_we,
  output logic [LEN_ADDR-1:0]    rf_waddr,
  output logic [LEN_OPECODE-1:0] alu_opecode,
  output logic                   alu_carry_i,
  input  logic                   alu_carry_o,
  input  logic [LEN_REG-1:0]     alu_data_o,
  output logic                   done,
  output logic                   flag_c,
  output logic                   flag_z
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic sub_q, sub_d, carry_q, carry_d, flag_c_q, flag_c_d;
  logic [LEN_CNT-1:0] len_q, len_d, idx_q, idx_d;
  logic [LEN_ADDR-1:0] brd_q, brd_d, brs_q, brs_d;
  logic first, last;
  assign first = idx_q == '0;
  assign last = LEN_CNT'(idx_q + 1'b1) == len_q;
  assign req_ready = state_q == IDLE;
  assign done = state_q == DONE;
  assign rf_we = state_q == RUN && !abort;
  assign rf_raddr_rd = brd_q + LEN_ADDR'(idx_q);
  assign rf_raddr_rs = brs_q + LEN_ADDR'(idx_q);
  assign rf_waddr = rf_raddr_rd;
  assign alu_opecode = first ? (sub_q ? OPECODE_SUB : OPECODE_ADD) : (sub_q ? OPECODE_SBC : OPECODE_ADC);
  assign alu_carry_i = !first && carry_q;
  assign flag_c = flag_c_q;
`ifdef MPADD_ZERO_FLAG_EN
  logic z_q, z_d, flag_z_q, flag_z_d, z_word;
  assign z_word = z_q && alu_data_o == '0;
  assign flag_z = flag_z_q;
`else
  assign flag_z = 1'b0 & |alu_data_o;
`endif
  always_comb begin
    state_d = state_q;
    sub_d = sub_q;
    len_d = len_q;
    brd_d = brd_q;
    brs_d = brs_q;
    idx_d = idx_q;
    carry_d = carry_q;
    flag_c_d = flag_c_q;
`ifdef MPADD_ZERO_FLAG_EN
    z_d = z_q;
    flag_z_d = flag_z_q;
`endif
    if (state_q == IDLE) begin
      if (req_valid) begin
        sub_d = req_sub;
        len_d = req_len;
        brd_d = req_base_rd;
        brs_d = req_base_rs;
        idx_d = '0;
        carry_d = 1'b0;
        state_d = req_len == '0 ? DONE : RUN;
        flag_c_d = req_len == '0 ? 1'b0 : flag_c_q;
`ifdef MPADD_ZERO_FLAG_EN
        z_d = 1'b1;
        flag_z_d = req_len == '0 ? 1'b1 : flag_z_q;
`endif
      end
    end else if (state_q == RUN) begin
      if (abort) begin
        state_d = IDLE;
      end else begin
        carry_d = alu_carry_o;
        idx_d = idx_q + 1'b1;
        state_d = last ? DONE : RUN;
        flag_c_d = last ? alu_carry_o : flag_c_q;
`ifdef MPADD_ZERO_FLAG_EN
        z_d = z_word;
        flag_z_d = last ? z_word : flag_z_q;
`endif
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sub_q <= 1'b0;
      len_q <= '0;
      brd_q <= '0;
      brs_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      flag_c_q <= 1'b0;
`ifdef MPADD_ZERO_FLAG_EN
      z_q <= 1'b0;
      flag_z_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sub_q <= sub_d;
      len_q <= len_d;
      brd_q <= brd_d;
      brs_q <= brs_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      flag_c_q <= flag_c_d;
`ifdef MPADD_ZERO_FLAG_EN
      z_q <= z_d;
      flag_z_q <= flag_z_d;
`endif
    end
  end
endmodule

// File: tb/tb_mpadd_sequencer.sv
// tb_mpadd_sequencer: drives mpadd_sequencer against a behavioural adder and 16x16 regfile,
// checking every word against a word-by-word arithmetic reference model.
module tb_mpadd_sequencer;
  localparam logic [5:0] OP_ADD = 6'd8, OP_ADC = 6'd9, OP_SUB = 6'd10, OP_SBC = 6'd11;
`ifdef MPADD_ZERO_FLAG_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_sub = 1'b0, abort = 1'b0;
  logic [2:0] req_len = '0;
  logic [3:0] req_base_rd = '0, req_base_rs = '0;
  logic req_ready, rf_we, alu_carry_i, alu_carry_o, done, flag_c, flag_z;
  logic [3:0] rf_raddr_rd, rf_raddr_rs, rf_waddr;
  logic [5:0] alu_opecode;
  logic [15:0] alu_data_o;
  logic [15:0] rf [16];
  logic [16:0] sum;
  int n_chk = 0, n_fail = 0, we_cnt = 0;
  logic fc_exp = 1'b0, fz_exp = 1'b0;

  always #5 clk = ~clk;

  mpadd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_len(req_len), .req_base_rd(req_base_rd), .req_base_rs(req_base_rs), .abort(abort),
    .rf_raddr_rd(rf_raddr_rd), .rf_raddr_rs(rf_raddr_rs), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .alu_opecode(alu_opecode), .alu_carry_i(alu_carry_i), .alu_carry_o(alu_carry_o),
    .alu_data_o(alu_data_o), .done(done), .flag_c(flag_c), .flag_z(flag_z)
  );

  always_comb begin
    if (alu_opecode == OP_SUB || alu_opecode == OP_SBC)
      sum = {1'b0, rf[rf_raddr_rd]} - {1'b0, rf[rf_raddr_rs]} - {16'd0, alu_opecode == OP_SBC && alu_carry_i};
    else
      sum = {1'b0, rf[rf_raddr_rd]} + {1'b0, rf[rf_raddr_rs]} + {16'd0, alu_opecode == OP_ADC && alu_carry_i};
  end
  assign alu_data_o = sum[15:0];
  assign alu_carry_o = sum[16];

  always @(posedge clk) begin
    if (rf_we) begin
      rf[rf_waddr] <= alu_data_o;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic fill_rf();
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: rf[i] = 16'h0000;
        1: rf[i] = 16'hFFFF;
        default: rf[i] = 16'($urandom);
      endcase
    end
  endtask

  // Issues one request from a negedge and returns at the first negedge where the block is idle again.
  task automatic do_op(input bit sub, input int len, input int rd, input int rs, input int ab, input string tag);
    logic [15:0] m [16];
    logic [3:0] wa [8];
    logic cin [8];
    logic c, z, fzx;
    logic [15:0] a, b, r;
    logic [5:0] op;
    int t, n, i;
    for (int k = 0; k < 16; k++) m[k] = rf[k];
    c = 1'b0;
    z = 1'b1;
    n = (ab >= 0 && ab < len) ? ab : len;
    for (int k = 0; k < len; k++) begin
      cin[k] = c;
      wa[k] = 4'((rd + k) % 16);
      a = m[wa[k]];
      b = m[(rs + k) % 16];
      if (sub) begin
        t = int'(a) - int'(b) - int'(c);
        c = t < 0;
      end else begin
        t = int'(a) + int'(b) + int'(c);
        c = t > 65535;
      end
      r = 16'(t);
      z = z && r == 16'd0;
      if (k < n) m[wa[k]] = r;
    end
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1;
    req_sub = sub;
    req_len = 3'(len);
    req_base_rd = 4'(rd);
    req_base_rs = 4'(rs);
    @(negedge clk);
    req_valid = 1'b0;
    req_sub = 1'($urandom);
    req_len = 3'($urandom);
    for (int cyc = 1; cyc <= len + 1; cyc++) begin
      i = cyc - 1;
      if (i == n && n < len) begin
        abort = 1'b1;
        #1;
        n_chk++;
        if (rf_we !== 1'b0) begin
          n_fail++;
          $display("FAIL %s abort_we: got %b want 0", tag, rf_we);
        end
        @(negedge clk);
        abort = 1'b0;
        fzx = ZF ? fz_exp : 1'b0;
        n_chk++;
        if ({req_ready, done, flag_c, flag_z} !== {1'b1, 1'b0, fc_exp, fzx}) begin
          n_fail++;
          $display("FAIL %s after_abort rdy/done/c/z: got %b%b%b%b want 1 0 %b %b", tag, req_ready, done, flag_c, flag_z, fc_exp, fzx);
        end
        n_chk++;
        if (rf !== m) begin
          n_fail++;
          $display("FAIL %s abort_regfile: r0..r3 got %h %h %h %h want %h %h %h %h", tag, rf[0], rf[1], rf[2], rf[3], m[0], m[1], m[2], m[3]);
        end
        return;
      end
      if (cyc <= len) begin
        op = i == 0 ? (sub ? OP_SUB : OP_ADD) : (sub ? OP_SBC : OP_ADC);
        n_chk++;
        if ({rf_we, req_ready, done, rf_waddr, rf_raddr_rd, rf_raddr_rs, alu_opecode, alu_carry_i} !==
            {1'b1, 1'b0, 1'b0, wa[i], wa[i], 4'((rs + i) % 16), op, cin[i]}) begin
          n_fail++;
          $display("FAIL %s run_word%0d we/rdy/done/wa/rd/rs/op/ci: got %b %b %b %h %h %h %h %b want 1 0 0 %h %h %h %h %b",
                   tag, i, rf_we, req_ready, done, rf_waddr, rf_raddr_rd, rf_raddr_rs, alu_opecode, alu_carry_i,
                   wa[i], wa[i], 4'((rs + i) % 16), op, cin[i]);
        end
      end else begin
        fc_exp = c;
        fz_exp = z;
        fzx = ZF ? z : 1'b0;
        n_chk++;
        if ({done, req_ready, rf_we, flag_c, flag_z} !== {1'b1, 1'b0, 1'b0, c, fzx}) begin
          n_fail++;
          $display("FAIL %s done_cycle done/rdy/we/c/z: got %b %b %b %b %b want 1 0 0 %b %b", tag, done, req_ready, rf_we, flag_c, flag_z, c, fzx);
        end
      end
      @(negedge clk);
    end
    fzx = ZF ? fz_exp : 1'b0;
    n_chk++;
    if ({done, req_ready, flag_c, flag_z} !== {1'b0, 1'b1, fc_exp, fzx}) begin
      n_fail++;
      $display("FAIL %s post_done done/rdy/c/z: got %b %b %b %b want 0 1 %b %b", tag, done, req_ready, flag_c, flag_z, fc_exp, fzx);
    end
    n_chk++;
    if (rf !== m) begin
      n_fail++;
      $display("FAIL %s regfile: r0..r3 got %h %h %h %h want %h %h %h %h", tag, rf[0], rf[1], rf[2], rf[3], m[0], m[1], m[2], m[3]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) rf[i] = 16'd0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({req_ready, rf_we, done, flag_c, flag_z, rf_raddr_rd, rf_raddr_rs, rf_waddr, alu_opecode, alu_carry_i} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, OP_ADD, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy%b we%b done%b c%b z%b %h %h %h op%h ci%b want 1 0 0 0 0 0 0 0 %h 0",
               req_ready, rf_we, done, flag_c, flag_z, rf_raddr_rd, rf_raddr_rs, rf_waddr, alu_opecode, alu_carry_i, OP_ADD);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    fill_rf();
    rf[0] = 16'hFFFF; rf[1] = 16'h0001; rf[4] = 16'h0001; rf[5] = 16'h0000;
    do_op(1'b0, 2, 0, 4, -1, "add2");
    n_chk++;
    if ({rf[0], rf[1], flag_c} !== {16'h0000, 16'h0002, 1'b0}) begin
      n_fail++;
      $display("FAIL add2_result: got %h %h c%b want 0000 0002 c0", rf[0], rf[1], flag_c);
    end
  endtask

  task automatic test_sub();
    rf[0] = 16'h0000; rf[1] = 16'h0000; rf[4] = 16'h0001; rf[5] = 16'h0000;
    do_op(1'b1, 2, 0, 4, -1, "sub2");
    n_chk++;
    if ({rf[0], rf[1], flag_c} !== {16'hFFFF, 16'hFFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL sub2_result: got %h %h c%b want FFFF FFFF c1", rf[0], rf[1], flag_c);
    end
  endtask

  task automatic test_wrap();
    fill_rf();
    we_cnt = 0;
    do_op(1'b0, 3, 14, 2, -1, "wrap");
    n_chk++;
    if (we_cnt !== 3) begin
      n_fail++;
      $display("FAIL wrap_we_count: got %0d want 3", we_cnt);
    end
  endtask

  task automatic test_len0();
    fill_rf();
    we_cnt = 0;
    do_op(1'b1, 0, 5, 9, -1, "len0");
    n_chk++;
    if ({we_cnt, flag_c} !== {32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL len0_writes_flag: got %0d c%b want 0 c0", we_cnt, flag_c);
    end
  endtask

  task automatic test_abort();
    fill_rf();
    we_cnt = 0;
    do_op(1'b0, 4, 6, 1, 1, "abort");
    n_chk++;
    if (we_cnt !== 1) begin
      n_fail++;
      $display("FAIL abort_we_count: got %0d want 1", we_cnt);
    end
    do_op(1'b1, 1, 2, 3, -1, "after_abort_req");
  endtask

  task automatic test_zero_flag();
    fill_rf();
    rf[0] = 16'hFFFF; rf[4] = 16'h0001;
    do_op(1'b0, 1, 0, 4, -1, "zflag");
    n_chk++;
    if ({flag_c, flag_z} !== {1'b1, ZF}) begin
      n_fail++;
      $display("FAIL zflag_result: got c%b z%b want c1 z%b", flag_c, flag_z, ZF);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] snap [16];
    fill_rf();
    req_valid = 1'b1; req_sub = 1'b0; req_len = 3'd5; req_base_rd = 4'd3; req_base_rs = 4'd9;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({req_ready, rf_we, done, flag_c, flag_z, rf_raddr_rd, rf_raddr_rs, rf_waddr, alu_opecode, alu_carry_i} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, OP_ADD, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rdy%b we%b done%b c%b z%b %h %h %h op%h ci%b want 1 0 0 0 0 0 0 0 %h 0",
               req_ready, rf_we, done, flag_c, flag_z, rf_raddr_rd, rf_raddr_rs, rf_waddr, alu_opecode, alu_carry_i, OP_ADD);
    end
    snap = rf;
    we_cnt = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (we_cnt !== 0 || rf !== snap) begin
      n_fail++;
      $display("FAIL midreset_no_writes: got %0d writes want 0", we_cnt);
    end
    rst_n = 1'b1;
    fc_exp = 1'b0;
    fz_exp = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int ab;
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) fill_rf();
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      do_op(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), ab, "rand");
    end
  endtask

  task automatic test_back_to_back();
    fill_rf();
    do_op(1'b0, 7, 0, 0, -1, "b2b_double");
    do_op(1'b1, 7, 9, 8, -1, "b2b_sub");
    do_op(1'b0, 0, 1, 1, -1, "b2b_len0");
    do_op(1'b0, 2, 15, 14, -1, "b2b_add");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_wrap();
    test_len0();
    test_abort();
    test_zero_flag();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
